axi_4_lite_slv_regfile: RTL and testbench
=========================================

// Module: axi_4_lite_slv_regfile
// PURPOSE
//   Parametrised AXI4-Lite slave register file. Next generation of the fixed 32x32 AXI4-Lite slave.
//   - Register count, data width and address width are configurable.
//   - AW and W channels are accepted independently, in either order.
//   - Writes to read-only registers, and accesses out of range, return SLVERR.
//   - A one-cycle write pulse per register goes to user logic.
//   - Sits between the PS AXI GP port (via interconnect) and PL control/status logic.
// PARAMETERS
//   C_DATA_WIDTH  32   data bus width, 32 or 64; strobe width = C_DATA_WIDTH/8
//   C_ADDR_WIDTH  8    AXI address width
//   C_NUM_REGS    32   number of registers, 1..256; index width IDXW = max(1,clog2(C_NUM_REGS))
//   C_RO_MASK     0    C_NUM_REGS-bit mask; bit i=1 makes reg i read-only (AXI writes rejected)
//   C_RESET_VAL   0    reset value loaded into every register
// PORTS
//   S_AXI_ACLK       in   1             clock, rising edge
//   S_AXI_ARESETN    in   1             reset, asynchronous assert, active-low
//   S_AXI_AWVALID    in   1             write address valid
//   S_AXI_AWREADY    out  1             write address ready
//   S_AXI_AWADDR     in   C_ADDR_WIDTH  write byte address
//   S_AXI_AWPROT     in   3             ignored
//   S_AXI_WVALID     in   1             write data valid
//   S_AXI_WREADY     out  1             write data ready
//   S_AXI_WDATA      in   C_DATA_WIDTH  write data
//   S_AXI_WSTRB      in   C_DATA_WIDTH/8  byte enables
//   S_AXI_BVALID     out  1             write response valid
//   S_AXI_BREADY     in   1             write response ready
//   S_AXI_BRESP      out  2             00 OKAY, 10 SLVERR
//   S_AXI_ARVALID    in   1             read address valid
//   S_AXI_ARREADY    out  1             read address ready
//   S_AXI_ARADDR     in   C_ADDR_WIDTH  read byte address
//   S_AXI_ARPROT     in   3             ignored
//   S_AXI_RVALID     out  1             read data valid
//   S_AXI_RREADY     in   1             read data ready
//   S_AXI_RDATA      out  C_DATA_WIDTH  read data
//   S_AXI_RRESP      out  2             00 OKAY, 10 SLVERR
//   REG_WR_PULSE     out  C_NUM_REGS    bit i high for one cycle after reg i is updated
//   DEB_READ_INDEX   out  IDXW          index of the last accepted read address
//   DEB_WRITE_INDEX  out  IDXW          index of the last accepted write address
// BEHAVIOUR
//   Reset (ARESETN=0, asynchronous):
//   - All registers = C_RESET_VAL.
//   - AWREADY=WREADY=ARREADY=0; BVALID=RVALID=0; BRESP=RRESP=00; RDATA=0.
//   - REG_WR_PULSE=0; DEB_*=0. Any in-flight transaction is discarded.
//   - All READY outputs rise on the first clock edge after reset release.
//   Address decode:
//   - idx = addr[ADDR_LSB +: IDXW], where ADDR_LSB = clog2(C_DATA_WIDTH/8). Low ADDR_LSB bits ignored.
//   - Out of range if idx >= C_NUM_REGS or any addr bit above ADDR_LSB+IDXW is nonzero.
//   Write path (states W_IDLE -> W_RESP):
//   - W_IDLE: AWREADY=!aw_held and WREADY=!w_held. Each handshake latches its channel;
//     both may complete in the same cycle or in either order.
//   - When both are held: on the next edge, commit and enter W_RESP with BVALID=1.
//   - Commit: bytes with WSTRB=1 are updated and REG_WR_PULSE[idx] pulses for one cycle.
//   - Read-only or out-of-range target: no update, no pulse, BRESP=10. Otherwise BRESP=00.
//   - WSTRB=0 on a valid register: OKAY, no update, no pulse.
//   - W_RESP: AWREADY=WREADY=0. BVALID and BRESP are held until BREADY.
//     After the B handshake, held flags clear and the block returns to W_IDLE.
//   - Minimum write: AW+W handshake at edge N, BVALID at edge N+1, AWREADY at edge N+2 after BREADY.
//   Read path (states R_IDLE -> R_DATA):
//   - R_IDLE: ARREADY=1. On AR handshake, at the same edge: RVALID=1,
//     RDATA=reg[idx] (value before any same-edge write), RRESP=00.
//   - Out of range: RDATA=0, RRESP=10.
//   - R_DATA: ARREADY=0. RDATA and RRESP are held stable until RREADY.
//     After the R handshake, ARREADY=1 on the next edge.
//   - Read and write channels are fully independent and may be active simultaneously.
//   - Same-register read and commit on the same edge: the read returns the old value.
// TESTING
//   1 Write reg0 = 0xDEADBEEF with WSTRB=1111, then read reg0 -> RDATA=0xDEADBEEF, BRESP=RRESP=00, REG_WR_PULSE[0] one cycle.
//   2 W issued 3 cycles before AW on reg5: write 0xFFFFFFFF, then 0x00563400 with WSTRB=0110 -> read reg5 = 0xFF5634FF.
//   3 C_RO_MASK bit 2 set; write 0x12345678 to reg2 -> BRESP=10, no pulse, read reg2 = C_RESET_VAL with RRESP=00.
//   4 Read addr C_NUM_REGS*4 (e.g. 0x80 with C_NUM_REGS=32) -> RDATA=0, RRESP=10; write there -> BRESP=10.
//   5 Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID, BRESP/RDATA stable; AWREADY/WREADY/ARREADY stay 0.
//   6 Drop ARESETN mid-write (after AW, before W) -> outputs reset immediately; next write to reg31 = 0xA5A5A5A5 reads back correctly.

Source files
------------

// File: rtl/axi_4_lite_slv_regfile.sv
`default_nettype none
// ============================================================================
// Module      : axi_4_lite_slv_regfile
// Description : Parametrised AXI4-Lite slave register file with per-register
//               read-only mask, SLVERR on bad accesses and write pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_4_lite_slv_regfile #(
    parameter int                      C_DATA_WIDTH = 32,
    parameter int                      C_ADDR_WIDTH = 8,
    parameter int                      C_NUM_REGS   = 32,
    parameter logic [C_NUM_REGS-1:0]   C_RO_MASK    = '0,
    parameter logic [C_DATA_WIDTH-1:0] C_RESET_VAL  = '0,
    localparam int                     IDXW         = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1
) (
    input  logic                      S_AXI_ACLK,
    input  logic                      S_AXI_ARESETN,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [C_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                S_AXI_AWPROT,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    input  logic [C_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    output logic [1:0]                S_AXI_BRESP,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    input  logic [C_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                S_AXI_ARPROT,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,
    output logic [C_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic [C_NUM_REGS-1:0]     REG_WR_PULSE,
    output logic [IDXW-1:0]           DEB_READ_INDEX,
    output logic [IDXW-1:0]           DEB_WRITE_INDEX
);

    localparam int            c_strbw    = C_DATA_WIDTH / 8;
    localparam int            c_addr_lsb = $clog2(c_strbw);
    localparam logic [IDXW:0] c_num_regs = C_NUM_REGS[IDXW:0];

    localparam logic [0:0] c_w_idle = 1'b0;
    localparam logic [0:0] c_w_resp = 1'b1;
    localparam logic [0:0] c_r_idle = 1'b0;
    localparam logic [0:0] c_r_data = 1'b1;

    logic                    r_rdy_en;
    logic [0:0]              r_wstate;
    logic [0:0]              r_rstate;
    logic                    r_aw_held;
    logic                    r_w_held;
    logic [C_ADDR_WIDTH-1:0] r_aw_addr;
    logic [C_DATA_WIDTH-1:0] r_w_data;
    logic [c_strbw-1:0]      r_w_strb;
    logic [1:0]              r_bresp;
    logic [1:0]              r_rresp;
    logic [C_DATA_WIDTH-1:0] r_rdata;
    logic [C_NUM_REGS-1:0]   r_wr_pulse;
    logic [IDXW-1:0]         r_deb_rd_idx;
    logic [IDXW-1:0]         r_deb_wr_idx;
    logic [C_DATA_WIDTH-1:0] r_regs [C_NUM_REGS];

    // An address is valid only if its index is below the register count and
    // no bit above the index field is set (no aliasing onto low registers).
    function automatic logic f_in_range(input logic [C_ADDR_WIDTH-1:0] addr);
        logic [C_ADDR_WIDTH-1:0] upper;
        upper = addr >> (c_addr_lsb + IDXW);
        return (upper == '0) && ({1'b0, addr[c_addr_lsb +: IDXW]} < c_num_regs);
    endfunction

    logic            w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic            w_commit, w_wr_ok, w_ar_ok;
    logic [IDXW-1:0] w_wr_idx, w_ar_idx;
    logic            w_unused;

    assign S_AXI_AWREADY   = r_rdy_en && (r_wstate == c_w_idle) && !r_aw_held;
    assign S_AXI_WREADY    = r_rdy_en && (r_wstate == c_w_idle) && !r_w_held;
    assign S_AXI_BVALID    = (r_wstate == c_w_resp);
    assign S_AXI_BRESP     = r_bresp;
    assign S_AXI_ARREADY   = r_rdy_en && (r_rstate == c_r_idle);
    assign S_AXI_RVALID    = (r_rstate == c_r_data);
    assign S_AXI_RDATA     = r_rdata;
    assign S_AXI_RRESP     = r_rresp;
    assign REG_WR_PULSE    = r_wr_pulse;
    assign DEB_READ_INDEX  = r_deb_rd_idx;
    assign DEB_WRITE_INDEX = r_deb_wr_idx;

    assign w_aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
    assign w_b_hs   = S_AXI_BVALID  && S_AXI_BREADY;
    assign w_ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_r_hs   = S_AXI_RVALID  && S_AXI_RREADY;
    assign w_commit = (r_wstate == c_w_idle) && r_aw_held && r_w_held;
    assign w_wr_idx = r_aw_addr[c_addr_lsb +: IDXW];
    assign w_ar_idx = S_AXI_ARADDR[c_addr_lsb +: IDXW];
    assign w_wr_ok  = f_in_range(r_aw_addr) && !C_RO_MASK[w_wr_idx];
    assign w_ar_ok  = f_in_range(S_AXI_ARADDR);
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // Write channel: AW and W are latched independently, committed together.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rdy_en     <= 1'b0;
            r_wstate     <= c_w_idle;
            r_aw_held    <= 1'b0;
            r_w_held     <= 1'b0;
            r_aw_addr    <= '0;
            r_w_data     <= '0;
            r_w_strb     <= '0;
            r_bresp      <= 2'b00;
            r_deb_wr_idx <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_aw_hs) begin
                r_aw_held    <= 1'b1;
                r_aw_addr    <= S_AXI_AWADDR;
                r_deb_wr_idx <= S_AXI_AWADDR[c_addr_lsb +: IDXW];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_w_data <= S_AXI_WDATA;
                r_w_strb <= S_AXI_WSTRB;
            end
            case (r_wstate)
                c_w_idle: begin
                    if (w_commit) begin
                        r_wstate <= c_w_resp;
                        r_bresp  <= w_wr_ok ? 2'b00 : 2'b10;
                    end
                end
                c_w_resp: begin
                    if (w_b_hs) begin
                        r_wstate  <= c_w_idle;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                    end
                end
                default: r_wstate <= c_w_idle;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_regs[i] <= C_RESET_VAL;
            end
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit && w_wr_ok && (|r_w_strb)) begin
                for (int b = 0; b < c_strbw; b++) begin
                    if (r_w_strb[b]) begin
                        r_regs[w_wr_idx][8*b +: 8] <= r_w_data[8*b +: 8];
                    end
                end
                r_wr_pulse[w_wr_idx] <= 1'b1;
            end
        end
    end

    // Read channel: data is captured at the AR handshake edge, so a write
    // committing on that same edge is not yet visible.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rstate     <= c_r_idle;
            r_rdata      <= '0;
            r_rresp      <= 2'b00;
            r_deb_rd_idx <= '0;
        end else begin
            case (r_rstate)
                c_r_idle: begin
                    if (w_ar_hs) begin
                        r_rstate     <= c_r_data;
                        r_deb_rd_idx <= w_ar_idx;
                        if (w_ar_ok) begin
                            r_rdata <= r_regs[w_ar_idx];
                            r_rresp <= 2'b00;
                        end else begin
                            r_rdata <= '0;
                            r_rresp <= 2'b10;
                        end
                    end
                end
                c_r_data: begin
                    if (w_r_hs) begin
                        r_rstate <= c_r_idle;
                    end
                end
                default: r_rstate <= c_r_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_4_lite_slv_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_4_lite_slv_regfile
// Description : Self-checking bench for axi_4_lite_slv_regfile (32x32, reg2 RO).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_4_lite_slv_regfile;

    localparam int          NREGS = 32;
    localparam logic [31:0] RO    = 32'h0000_0004;
    localparam logic [31:0] RSTV  = 32'hC0FF_EE00;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [7:0]  awaddr, araddr;
    logic [31:0] wdata, rdata, wr_pulse;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [4:0]  deb_rd, deb_wr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mdl [NREGS];

    always #5 clk = ~clk;

    axi_4_lite_slv_regfile #(
        .C_DATA_WIDTH(32), .C_ADDR_WIDTH(8), .C_NUM_REGS(NREGS),
        .C_RO_MASK(RO), .C_RESET_VAL(RSTV)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .REG_WR_PULSE(wr_pulse), .DEB_READ_INDEX(deb_rd), .DEB_WRITE_INDEX(deb_wr)
    );

    // Reference model: byte address / 4 selects a register; anything at or
    // beyond the register count is an error, as is writing a read-only one.
    task automatic mdl_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [31:0] pulse);
        int idx;
        idx   = int'(a) / 4;
        pulse = 32'h0;
        if (idx >= NREGS || RO[idx]) begin
            resp = 2'b10;
        end else begin
            resp = 2'b00;
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
            if (s != 4'h0) pulse = 32'h1 << idx;
        end
    endtask

    task automatic mdl_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int idx;
        idx = int'(a) / 4;
        if (idx >= NREGS) begin d = 32'h0; resp = 2'b10; end
        else begin d = mdl[idx]; resp = 2'b00; end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output logic [31:0] pulse_or, output int pulse_cnt);
        bit aw_done = 0, w_done = 0, b_done = 0, b_seen = 0, hs_aw, hs_w, hs_b;
        int cyc = 0;
        resp = 2'bxx; pulse_or = 0; pulse_cnt = 0;
        while (!(aw_done && w_done) && cyc < 100) begin
            @(negedge clk);
            if (|wr_pulse) begin pulse_cnt++; pulse_or |= wr_pulse; end
            awvalid = !aw_done && cyc >= aw_dly; awaddr = a;
            wvalid  = !w_done && cyc >= w_dly;   wdata = d; wstrb = s;
            hs_aw = awvalid && awready; hs_w = wvalid && wready;
            @(posedge clk);
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done = 1;
            cyc++;
        end
        cyc = 0;
        while (!b_done && cyc < 100) begin
            @(negedge clk);
            awvalid = 0; wvalid = 0;
            if (|wr_pulse) begin pulse_cnt++; pulse_or |= wr_pulse; end
            bready = (cyc >= b_dly);
            if (bvalid) begin
                if (!b_seen) begin b_seen = 1; resp = bresp; end
                else begin
                    n_checks++;
                    if (bresp !== resp) begin n_fail++; $error("FAIL bresp_stable: observed=0x%0h expected=0x%0h", bresp, resp); end
                end
                n_checks++;
                if (awready !== 1'b0) begin n_fail++; $error("FAIL awready_in_resp: observed=0x%0h expected=0x0", awready); end
                n_checks++;
                if (wready !== 1'b0) begin n_fail++; $error("FAIL wready_in_resp: observed=0x%0h expected=0x0", wready); end
            end
            hs_b = bvalid && bready;
            @(posedge clk);
            if (hs_b) b_done = 1;
            cyc++;
        end
        @(negedge clk);
        bready = 0;
        if (|wr_pulse) begin pulse_cnt++; pulse_or |= wr_pulse; end
        n_checks++;
        if ({aw_done, w_done, b_done} !== 3'b111) begin n_fail++; $error("FAIL write_done: observed=0x%0h expected=0x7", {aw_done, w_done, b_done}); end
        n_checks++;
        if (awready !== 1'b1) begin n_fail++; $error("FAIL awready_after_b: observed=0x%0h expected=0x1", awready); end
    endtask

    task automatic axi_read(input logic [7:0] a, input int ar_dly, input int r_dly,
                            output logic [31:0] d, output logic [1:0] resp);
        bit ar_done = 0, r_done = 0, r_seen = 0, hs;
        int cyc = 0;
        d = 32'hx; resp = 2'bxx;
        while (!ar_done && cyc < 100) begin
            @(negedge clk);
            arvalid = cyc >= ar_dly; araddr = a;
            hs = arvalid && arready;
            @(posedge clk);
            if (hs) ar_done = 1;
            cyc++;
        end
        cyc = 0;
        while (!r_done && cyc < 100) begin
            @(negedge clk);
            arvalid = 0;
            if (cyc == 0) begin
                n_checks++;
                if (rvalid !== 1'b1) begin n_fail++; $error("FAIL rvalid_latency: observed=0x%0h expected=0x1", rvalid); end
            end
            rready = (cyc >= r_dly);
            if (rvalid) begin
                if (!r_seen) begin r_seen = 1; d = rdata; resp = rresp; end
                else begin
                    n_checks++;
                    if (rdata !== d) begin n_fail++; $error("FAIL rdata_stable: observed=0x%0h expected=0x%0h", rdata, d); end
                    n_checks++;
                    if (rresp !== resp) begin n_fail++; $error("FAIL rresp_stable: observed=0x%0h expected=0x%0h", rresp, resp); end
                end
                n_checks++;
                if (arready !== 1'b0) begin n_fail++; $error("FAIL arready_in_data: observed=0x%0h expected=0x0", arready); end
            end
            hs = rvalid && rready;
            @(posedge clk);
            if (hs) r_done = 1;
            cyc++;
        end
        @(negedge clk);
        rready = 0;
        n_checks++;
        if ({ar_done, r_done} !== 2'b11) begin n_fail++; $error("FAIL read_done: observed=0x%0h expected=0x3", {ar_done, r_done}); end
        n_checks++;
        if (arready !== 1'b1) begin n_fail++; $error("FAIL arready_after_r: observed=0x%0h expected=0x1", arready); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp, eresp;
        logic [31:0] rd, ed, pulse_or, epulse;
        int          pcnt;
        logic [7:0]  a;

        aresetn = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
        for (int i = 0; i < NREGS; i++) mdl[i] = RSTV;

        repeat (3) @(negedge clk);
        n_checks++;
        if ({awready, wready, arready} !== 3'b000) begin n_fail++; $error("FAIL rst_ready: observed=0x%0h", {awready, wready, arready}); end
        n_checks++;
        if ({bvalid, rvalid} !== 2'b00) begin n_fail++; $error("FAIL rst_valid: observed=0x%0h", {bvalid, rvalid}); end
        n_checks++;
        if ({bresp, rresp} !== 4'h0) begin n_fail++; $error("FAIL rst_resp: observed=0x%0h", {bresp, rresp}); end
        n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $error("FAIL rst_rdata: observed=0x%0h", rdata); end
        n_checks++;
        if (wr_pulse !== 32'h0) begin n_fail++; $error("FAIL rst_pulse: observed=0x%0h", wr_pulse); end
        n_checks++;
        if ({deb_rd, deb_wr} !== 10'h0) begin n_fail++; $error("FAIL rst_deb: observed=0x%0h", {deb_rd, deb_wr}); end
        aresetn = 1;
        #1;
        n_checks++;
        if ({awready, wready, arready} !== 3'b000) begin n_fail++; $error("FAIL ready_before_edge: observed=0x%0h", {awready, wready, arready}); end
        @(negedge clk);
        n_checks++;
        if ({awready, wready, arready} !== 3'b111) begin n_fail++; $error("FAIL ready_after_edge: observed=0x%0h", {awready, wready, arready}); end

        axi_read(8'h1C, 0, 0, rd, resp);
        n_checks++;
        if (rd !== RSTV) begin n_fail++; $error("FAIL reset_val_reg7: observed=0x%0h expected=0x%0h", rd, RSTV); end

        mdl_write(8'h00, 32'hDEADBEEF, 4'hF, eresp, epulse);
        axi_write(8'h00, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, pulse_or, pcnt);
        n_checks++;
        if (resp !== 2'b00) begin n_fail++; $error("FAIL t1_bresp: observed=0x%0h", resp); end
        n_checks++;
        if (pulse_or !== 32'h1) begin n_fail++; $error("FAIL t1_pulse: observed=0x%0h", pulse_or); end
        n_checks++;
        if (pcnt !== 1) begin n_fail++; $error("FAIL t1_pulse_len: observed=%0d", pcnt); end
        axi_read(8'h00, 0, 0, rd, resp);
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_fail++; $error("FAIL t1_rdata: observed=0x%0h", rd); end
        n_checks++;
        if (resp !== 2'b00) begin n_fail++; $error("FAIL t1_rresp: observed=0x%0h", resp); end

        mdl_write(8'h14, 32'hFFFFFFFF, 4'hF, eresp, epulse);
        axi_write(8'h14, 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp, pulse_or, pcnt);
        mdl_write(8'h14, 32'h00563400, 4'h6, eresp, epulse);
        axi_write(8'h14, 32'h00563400, 4'h6, 3, 0, 0, resp, pulse_or, pcnt);
        n_checks++;
        if (pulse_or !== 32'h20) begin n_fail++; $error("FAIL t2_pulse: observed=0x%0h", pulse_or); end
        n_checks++;
        if (deb_wr !== 5'd5) begin n_fail++; $error("FAIL t2_deb_wr: observed=0x%0h", deb_wr); end
        axi_read(8'h14, 0, 0, rd, resp);
        n_checks++;
        if (rd !== 32'hFF5634FF) begin n_fail++; $error("FAIL t2_rdata: observed=0x%0h", rd); end
        n_checks++;
        if (deb_rd !== 5'd5) begin n_fail++; $error("FAIL t2_deb_rd: observed=0x%0h", deb_rd); end

        axi_write(8'h08, 32'h12345678, 4'hF, 0, 2, 0, resp, pulse_or, pcnt);
        n_checks++;
        if (resp !== 2'b10) begin n_fail++; $error("FAIL t3_bresp: observed=0x%0h", resp); end
        n_checks++;
        if (pcnt !== 0) begin n_fail++; $error("FAIL t3_pulse: observed=%0d", pcnt); end
        axi_read(8'h08, 0, 0, rd, resp);
        n_checks++;
        if (rd !== RSTV) begin n_fail++; $error("FAIL t3_rdata: observed=0x%0h", rd); end
        n_checks++;
        if (resp !== 2'b00) begin n_fail++; $error("FAIL t3_rresp: observed=0x%0h", resp); end

        axi_read(8'h80, 0, 0, rd, resp);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $error("FAIL t4_rdata: observed=0x%0h", rd); end
        n_checks++;
        if (resp !== 2'b10) begin n_fail++; $error("FAIL t4_rresp: observed=0x%0h", resp); end
        axi_write(8'h80, 32'h11111111, 4'hF, 0, 0, 0, resp, pulse_or, pcnt);
        n_checks++;
        if (resp !== 2'b10) begin n_fail++; $error("FAIL t4_bresp: observed=0x%0h", resp); end
        n_checks++;
        if (pcnt !== 0) begin n_fail++; $error("FAIL t4_pulse: observed=%0d", pcnt); end
        axi_read(8'h00, 0, 0, rd, resp);
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_fail++; $error("FAIL t4_no_alias: observed=0x%0h", rd); end
        axi_write(8'h24, 32'h99999999, 4'h0, 0, 0, 0, resp, pulse_or, pcnt);
        n_checks++;
        if (resp !== 2'b00) begin n_fail++; $error("FAIL strb0_bresp: observed=0x%0h", resp); end
        n_checks++;
        if (pcnt !== 0) begin n_fail++; $error("FAIL strb0_pulse: observed=%0d", pcnt); end
        axi_read(8'h24, 0, 0, rd, resp);
        n_checks++;
        if (rd !== RSTV) begin n_fail++; $error("FAIL strb0_rdata: observed=0x%0h", rd); end

        mdl_write(8'h28, 32'h0BADF00D, 4'hF, eresp, epulse);
        axi_write(8'h28, 32'h0BADF00D, 4'hF, 0, 0, 6, resp, pulse_or, pcnt);
        n_checks++;
        if (resp !== 2'b00) begin n_fail++; $error("FAIL t5_bresp: observed=0x%0h", resp); end
        axi_read(8'h28, 0, 6, rd, resp);
        n_checks++;
        if (rd !== 32'h0BADF00D) begin n_fail++; $error("FAIL t5_rdata: observed=0x%0h", rd); end

        for (int k = 0; k < 40; k++) begin
            a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 1) begin
                ed = $urandom;
                wstrb = 4'($urandom_range(0, 15));
                mdl_write(a, ed, wstrb, eresp, epulse);
                axi_write(a, ed, wstrb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                          resp, pulse_or, pcnt);
                n_checks++;
                if (resp !== eresp) begin n_fail++; $error("FAIL rnd_bresp: observed=0x%0h expected=0x%0h", resp, eresp); end
                n_checks++;
                if (pulse_or !== epulse) begin n_fail++; $error("FAIL rnd_pulse: observed=0x%0h expected=0x%0h", pulse_or, epulse); end
                n_checks++;
                if (pcnt !== ((epulse != 0) ? 1 : 0)) begin n_fail++; $error("FAIL rnd_pulse_len: observed=%0d", pcnt); end
                n_checks++;
                if (deb_wr !== 5'((int'(a) / 4) % NREGS)) begin n_fail++; $error("FAIL rnd_deb_wr: observed=0x%0h", deb_wr); end
            end else begin
                mdl_read(a, ed, eresp);
                axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3), rd, resp);
                n_checks++;
                if (rd !== ed) begin n_fail++; $error("FAIL rnd_rdata: observed=0x%0h expected=0x%0h", rd, ed); end
                n_checks++;
                if (resp !== eresp) begin n_fail++; $error("FAIL rnd_rresp: observed=0x%0h expected=0x%0h", resp, eresp); end
            end
        end

        @(negedge clk);
        awvalid = 1; awaddr = 8'h7C;
        @(posedge clk);
        @(negedge clk);
        awvalid = 0;
        n_checks++;
        if (deb_wr !== 5'd31) begin n_fail++; $error("FAIL t6_deb_wr_pre: observed=0x%0h", deb_wr); end
        n_checks++;
        if (awready !== 1'b0) begin n_fail++; $error("FAIL t6_awready_held: observed=0x%0h", awready); end
        #2 aresetn = 0;
        #1;
        n_checks++;
        if ({awready, wready, arready} !== 3'b000) begin n_fail++; $error("FAIL t6_rst_ready: observed=0x%0h", {awready, wready, arready}); end
        n_checks++;
        if ({bvalid, rvalid} !== 2'b00) begin n_fail++; $error("FAIL t6_rst_valid: observed=0x%0h", {bvalid, rvalid}); end
        n_checks++;
        if ({deb_rd, deb_wr} !== 10'h0) begin n_fail++; $error("FAIL t6_rst_deb: observed=0x%0h", {deb_rd, deb_wr}); end
        n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $error("FAIL t6_rst_rdata: observed=0x%0h", rdata); end
        for (int i = 0; i < NREGS; i++) mdl[i] = RSTV;
        repeat (2) @(negedge clk);
        aresetn = 1;
        @(negedge clk);
        n_checks++;
        if ({awready, wready, arready} !== 3'b111) begin n_fail++; $error("FAIL t6_ready_back: observed=0x%0h", {awready, wready, arready}); end
        axi_write(8'h7C, 32'hA5A5A5A5, 4'hF, 0, 0, 0, resp, pulse_or, pcnt);
        n_checks++;
        if (resp !== 2'b00) begin n_fail++; $error("FAIL t6_bresp: observed=0x%0h", resp); end
        n_checks++;
        if (pulse_or !== 32'h8000_0000) begin n_fail++; $error("FAIL t6_pulse: observed=0x%0h", pulse_or); end
        axi_read(8'h7C, 0, 0, rd, resp);
        n_checks++;
        if (rd !== 32'hA5A5A5A5) begin n_fail++; $error("FAIL t6_rdata: observed=0x%0h", rd); end
        axi_read(8'h00, 0, 0, rd, resp);
        n_checks++;
        if (rd !== RSTV) begin n_fail++; $error("FAIL t6_reg0_reset: observed=0x%0h", rd); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
